// File: rtl/multi_alarm_core_if.sv
// Bus bundle between the keyboard/controller side and the alarm core.
// The master drives the requests and loads; the slave (the core) drives
// the time, ring status and load-error pulse.
interface multi_alarm_core_if #(
    parameter int NUM_ALARMS = 4,
    parameter int ALW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
    logic            one_minute;
    logic            load_time;
    logic [15:0]     time_in;
    logic            load_alarm;
    logic [ALW-1:0]  alarm_sel;
    logic [15:0]     alarm_in;
    logic            alarm_en_in;
    logic            snooze;
    logic            stop_alarm;

    logic [15:0]     current_time;
    logic            sound_alarm;
    logic            snoozing;
    logic [ALW-1:0]  active_alarm;
    logic [3:0]      snooze_count;
    logic            load_err;

    modport master (
        output one_minute, load_time, time_in, load_alarm, alarm_sel,
               alarm_in, alarm_en_in, snooze, stop_alarm,
        input  current_time, sound_alarm, snoozing, active_alarm,
               snooze_count, load_err
    );

    modport slave (
        input  one_minute, load_time, time_in, load_alarm, alarm_sel,
               alarm_in, alarm_en_in, snooze, stop_alarm,
        output current_time, sound_alarm, snoozing, active_alarm,
               snooze_count, load_err
    );
endinterface

// File: rtl/multi_alarm_core.sv
// Timekeeping and alarm engine: 24-hour BCD HH:MM clock, NUM_ALARMS
// enable-gated alarm slots, and a ring/snooze state machine with a snooze
// limit and an unanswered-ring auto-off timeout.
module multi_alarm_core #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 9,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_MIN = 30,
    parameter int ALW              = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multi_alarm_core_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    // A BCD HH:MM word is legal only as a real time of day 00:00..23:59.
    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9) &&
               ((v[15:12] < 4'd2) || (v[11:8] <= 4'd3));
    endfunction

    // One-minute BCD increment with ripple carries and 23:59 -> 00:00 wrap.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] h1, h0, m1, m0;
        {h1, h0, m1, m0} = v;
        if (v == 16'h2359) begin
            return 16'h0000;
        end
        if (m0 == 4'd9) begin
            m0 = 4'd0;
            if (m1 == 4'd5) begin
                m1 = 4'd0;
                if (h0 == 4'd9) begin
                    h0 = 4'd0;
                    h1 = h1 + 4'd1;
                end else begin
                    h0 = h0 + 4'd1;
                end
            end else begin
                m1 = m1 + 4'd1;
            end
        end else begin
            m0 = m0 + 4'd1;
        end
        return {h1, h0, m1, m0};
    endfunction

    // Time-of-day and alarm slot storage.
    logic [15:0]     r_time;
    logic [15:0]     r_alarm_time [NUM_ALARMS];
    logic            r_alarm_en   [NUM_ALARMS];
    logic            r_load_err;
    logic            r_match_pend;
    logic [ALW-1:0]  r_match_idx;

    // Ring/snooze control state.
    state_t          r_state;
    logic [ALW-1:0]  r_active;
    logic [3:0]      r_snooze_cnt;
    logic [7:0]      r_ring_min;
    logic [5:0]      r_countdown;

    state_t          w_state_next;
    logic [ALW-1:0]  w_active_next;
    logic [3:0]      w_snooze_cnt_next;
    logic [7:0]      w_ring_min_next;
    logic [5:0]      w_countdown_next;

    logic            w_time_ok;
    logic            w_alarm_ok;
    logic            w_sel_ok;
    logic            w_time_wr;
    logic            w_alarm_wr;
    logic            w_load_rej;
    logic            w_tick_adv;
    logic            w_cancel;
    logic [15:0]     w_time_inc;
    logic [NUM_ALARMS-1:0] w_match;
    logic [ALW-1:0]  w_match_idx;

    assign w_time_ok  = bcd_valid(bus.time_in);
    assign w_alarm_ok = bcd_valid(bus.alarm_in);
    assign w_sel_ok   = ({1'b0, bus.alarm_sel} < (ALW+1)'(NUM_ALARMS));
    assign w_time_wr  = bus.load_time & w_time_ok;
    assign w_alarm_wr = bus.load_alarm & w_alarm_ok & w_sel_ok;
    assign w_load_rej = (bus.load_time & ~w_time_ok) |
                        (bus.load_alarm & ~(w_alarm_ok & w_sel_ok));
    // Any load_time in the cycle suppresses the tick's alarm evaluation.
    assign w_tick_adv = bus.one_minute & ~bus.load_time;
    assign w_time_inc = bcd_inc(r_time);
    // Rewriting the slot that owns the current episode ends that episode.
    assign w_cancel   = bus.load_alarm & w_sel_ok & (bus.alarm_sel == r_active);

    // Per-slot comparators against the post-increment time, and slot write.
    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            assign w_match[gi] = r_alarm_en[gi] && (r_alarm_time[gi] == w_time_inc);

            // Slot register: cleared on reset, written by a valid load_alarm.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_alarm_time[gi] <= 16'h0000;
                    r_alarm_en[gi]   <= 1'b0;
                end else if (w_alarm_wr && (bus.alarm_sel == ALW'(gi))) begin
                    r_alarm_time[gi] <= bus.alarm_in;
                    r_alarm_en[gi]   <= bus.alarm_en_in;
                end
            end
        end
    endgenerate

    // Lowest-index matching slot wins.
    always_comb begin
        w_match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_match_idx = ALW'(i);
            end
        end
    end

    // Time counter, load-error pulse and the registered match that the FSM
    // consumes one edge after the time update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_time       <= 16'h0000;
            r_load_err   <= 1'b0;
            r_match_pend <= 1'b0;
            r_match_idx  <= '0;
        end else begin
            if (w_time_wr) begin
                r_time <= bus.time_in;
            end else if (bus.one_minute) begin
                r_time <= w_time_inc;
            end
            r_load_err   <= w_load_rej;
            r_match_pend <= w_tick_adv & (|w_match);
            r_match_idx  <= w_match_idx;
        end
    end

    // FSM state and episode counters register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_active     <= '0;
            r_snooze_cnt <= 4'd0;
            r_ring_min   <= 8'd0;
            r_countdown  <= 6'd0;
        end else begin
            r_state      <= w_state_next;
            r_active     <= w_active_next;
            r_snooze_cnt <= w_snooze_cnt_next;
            r_ring_min   <= w_ring_min_next;
            r_countdown  <= w_countdown_next;
        end
    end

    // Next-state logic: stop/cancel beat snooze, snooze beats the minute tick.
    always_comb begin
        w_state_next      = r_state;
        w_active_next     = r_active;
        w_snooze_cnt_next = r_snooze_cnt;
        w_ring_min_next   = r_ring_min;
        w_countdown_next  = r_countdown;
        case (r_state)
            ST_IDLE: begin
                if (r_match_pend) begin
                    w_state_next      = ST_RING;
                    w_active_next     = r_match_idx;
                    w_snooze_cnt_next = 4'd0;
                    w_ring_min_next   = 8'd0;
                end
            end
            ST_RING: begin
                if (w_cancel || bus.stop_alarm) begin
                    w_state_next      = ST_IDLE;
                    w_snooze_cnt_next = 4'd0;
                end else if (bus.snooze && (r_snooze_cnt < 4'(MAX_SNOOZE))) begin
                    w_state_next      = ST_SNOOZE;
                    w_countdown_next  = 6'(SNOOZE_MIN);
                    w_snooze_cnt_next = r_snooze_cnt + 4'd1;
                end else if (bus.one_minute) begin
                    if (r_ring_min == 8'(RING_TIMEOUT_MIN - 1)) begin
                        w_state_next      = ST_IDLE;
                        w_snooze_cnt_next = 4'd0;
                    end else begin
                        w_ring_min_next = r_ring_min + 8'd1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (w_cancel || bus.stop_alarm) begin
                    w_state_next      = ST_IDLE;
                    w_snooze_cnt_next = 4'd0;
                end else if (bus.one_minute) begin
                    if (r_countdown == 6'd1) begin
                        w_state_next    = ST_RING;
                        w_ring_min_next = 8'd0;
                    end else begin
                        w_countdown_next = r_countdown - 6'd1;
                    end
                end
            end
            default: begin
                w_state_next      = ST_IDLE;
                w_snooze_cnt_next = 4'd0;
            end
        endcase
    end

    assign bus.current_time = r_time;
    assign bus.sound_alarm  = (r_state == ST_RING);
    assign bus.snoozing     = (r_state == ST_SNOOZE);
    assign bus.active_alarm = r_active;
    assign bus.snooze_count = r_snooze_cnt;
    assign bus.load_err     = r_load_err;

endmodule
